csi_packet_sequencer: RTL and testbench
=======================================

// Module: csi_packet_sequencer
// PURPOSE
//  Sequences the 4-lane CSI-2 byte stream into the RAW10 depacker. Parses packet headers (short/long),
//  gates only RAW10 payload words to the depacker, generates frame/line syncs and counters, and
//  drops unsupported or malformed packets. Sits between lane aligner and mipi RAW10 depacker in user_proj_example.
// PARAMETERS
//  DATA_TYPE   8'h2B   long-packet DI forwarded as payload (RAW10)
//  MAX_WC      16'd4000 largest accepted word count; larger -> error + skip
//  CNT_W       16      width of frame/line counters
// PORTS
//  wb_clk_i     in   1      single clock
//  wb_rst_i     in   1      synchronous active-high reset
//  enable_i     in   1      sequencer enable (LA/wishbone controlled)
//  in_valid_i   in   1      input word valid
//  in_sop_i     in   1      first word of packet (header), qualified by in_valid_i
//  in_data_i    in   32     lane bytes; [7:0] first byte on wire
//  pay_valid_o  out  1      payload word to depacker valid
//  pay_data_o   out  32     payload word
//  pay_last_o   out  1      last payload word of line
//  fsync_o      out  1      high from FS to FE (active high)
//  lsync_o      out  1      high while RAW10 line payload in progress
//  frame_cnt_o  out  CNT_W  completed frames (FE count)
//  line_cnt_o   out  CNT_W  RAW10 lines completed in current frame
//  err_o        out  1      one-cycle error pulse
//  err_code_o   out  3      code of last error: 1 WC>MAX_WC, 2 WC%4!=0, 3 sop mid-packet, 4 ECC
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, err_code_o 0. Reset mid-packet aborts immediately.
//  Header word: DI=[7:0], WC=[23:8], ECC=[31:24]. Only in_valid_i cycles advance state.
//  States: IDLE -> HDR on in_valid_i&in_sop_i&enable_i (header decoded same cycle, one-word transit).
//   DI 0x00 FS: fsync_o<=1, line_cnt_o<=0; stay IDLE.  DI 0x01 FE: fsync_o<=0, frame_cnt_o++.
//   DI 0x02/0x03 (LS/LE) and other DI<0x10: ignored, stay IDLE.
//   DI==DATA_TYPE, WC<=MAX_WC, WC%4==0, WC!=0 -> PAYLOAD, word counter=WC/4, lsync_o<=1.
//   Other DI>=0x10, or RAW10 with bad WC -> SKIP, counter=(WC+5)>>2 (payload+2B CRC, padded).
//  PAYLOAD: each valid word -> pay_valid_o=1, pay_data_o=in_data_i next cycle (latency 1).
//   Final word: pay_last_o=1, lsync_o<=0, line_cnt_o++, -> CRC.
//  CRC: consume one word (CRC + 2 pad bytes, not checked), -> IDLE.  SKIP: consume counter words -> IDLE.
//  Words with in_sop_i=0 in IDLE are discarded. enable_i sampled only in IDLE; deassert mid-packet
//   completes current packet.
//  sop during PAYLOAD/CRC/SKIP: err code 3, current packet aborted (lsync_o<=0, no pay_last_o,
//   line_cnt_o unchanged), same word decoded as new header.
//  Counters wrap at 2^CNT_W-1 -> 0. FS while fsync_o=1: line_cnt_o cleared, no error.
//  err_o pulses the cycle after detection; err_code_o holds until next error or reset.
//  Outputs pay_*, lsync_o registered; no back-pressure (depacker always accepts).
// CONFIGURATION
//  CSI_ECC_CHECK_EN defined: header ECC computed over [23:0] per CSI-2 Hamming(24,6) table;
//   mismatch -> err code 4, header dropped, stay IDLE (no single-bit correction).
//  Not defined: ECC byte ignored; code 4 never produced.
// TESTING
//  FS, RAW10 hdr WC=20, 5 data words, CRC word, FE -> fsync 1..0, 5 pay_valid, last on 5th,
//   line_cnt=1, frame_cnt=1.
//  RAW10 hdr WC=22 -> err_o pulse, code 2, next 6 words skipped, no pay_valid_o.
//  DI=0x12 WC=8 then 3 words then FS -> no payload, fsync_o=1, no error.
//  sop asserted on 3rd word of WC=40 line -> err code 3, lsync_o=0, line_cnt unchanged, new hdr decoded.
//  in_valid_i gaps (1-of-3 duty) during WC=16 line -> exactly 4 pay_valid_o, data order preserved.
//  CSI_ECC_CHECK_EN: FS with ECC bit flipped -> err code 4, fsync_o stays 0; reset mid-line -> all 0.

Source files
------------

// File: rtl/csi_packet_sequencer.sv
// ---------------------------------------------------------------------------
// csi_packet_sequencer
//   Takes the 4-lane aligned CSI-2 word stream and forwards only RAW10 line
//   payload to the RAW10 depacker. Decodes short/long packet headers, keeps
//   frame/line sync levels and counters, and drops unsupported or malformed
//   packets.
//
//   Optional feature macro: CSI_ECC_CHECK_EN
//     defined     : header ECC is checked with the CSI-2 Hamming(24,6) table;
//                   on mismatch the header is dropped and error code 4 is raised.
//     not defined : the header ECC byte is ignored.
//
// Ports
//   wb_clk_i     in   clock
//   wb_rst_i     in   synchronous active-high reset
//   enable_i     in   sequencer enable, sampled only between packets
//   in_valid_i   in   input word valid
//   in_sop_i     in   first word of packet (header), qualified by in_valid_i
//   in_data_i    in   [31:0] lane bytes, [7:0] first on the wire
//   pay_valid_o  out  payload word valid (one cycle latency)
//   pay_data_o   out  [31:0] payload word
//   pay_last_o   out  last payload word of the line
//   fsync_o      out  high from frame start to frame end
//   lsync_o      out  high while a RAW10 line payload is in progress
//   frame_cnt_o  out  [CNT_W-1:0] completed frames
//   line_cnt_o   out  [CNT_W-1:0] RAW10 lines completed in the current frame
//   err_o        out  one-cycle error pulse
//   err_code_o   out  [2:0] last error: 1 WC>MAX_WC, 2 WC%4!=0, 3 sop mid-packet,
//                     4 header ECC
// ---------------------------------------------------------------------------
module csi_packet_sequencer #(
    parameter logic [7:0]  DATA_TYPE = 8'h2B,
    parameter logic [15:0] MAX_WC    = 16'd4000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             enable_i,
    input  logic             in_valid_i,
    input  logic             in_sop_i,
    input  logic [31:0]      in_data_i,
    output logic             pay_valid_o,
    output logic [31:0]      pay_data_o,
    output logic             pay_last_o,
    output logic             fsync_o,
    output logic             lsync_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic             err_o,
    output logic [2:0]       err_code_o
);

    localparam int unsigned WCNT_W = 16;

    localparam logic [7:0] DI_FS = 8'h00;
    localparam logic [7:0] DI_FE = 8'h01;

    localparam logic [2:0] ERR_WC_MAX = 3'd1;
    localparam logic [2:0] ERR_WC_MOD = 3'd2;
    localparam logic [2:0] ERR_SOP    = 3'd3;
    localparam logic [2:0] ERR_ECC    = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CRC,
        S_SKIP
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               pay_valid_d;
    logic [31:0]        pay_data_d;
    logic               pay_last_d;
    logic               fsync_d;
    logic               lsync_d;
    logic [CNT_W-1:0]   frame_cnt_d;
    logic [CNT_W-1:0]   line_cnt_d;
    logic               err_d;
    logic [2:0]         err_code_d;

    // Header fields, valid whenever the current word is a header
    logic [7:0]         hdr_di;
    logic [15:0]        hdr_wc;
    logic [WCNT_W-1:0]  skip_len;
    logic               ecc_ok;
    logic               start_hdr;

    assign hdr_di   = in_data_i[7:0];
    assign hdr_wc   = in_data_i[23:8];
    // Words to drop: payload plus 2-byte CRC, rounded up to whole words
    assign skip_len = WCNT_W'((17'(hdr_wc) + 17'd5) >> 2);

`ifdef CSI_ECC_CHECK_EN
    // Bit masks over header bits [23:0] for parity bits P0..P5
    localparam logic [23:0] ECC_M0 = 24'hF12CB7;
    localparam logic [23:0] ECC_M1 = 24'hF2555B;
    localparam logic [23:0] ECC_M2 = 24'h749A6D;
    localparam logic [23:0] ECC_M3 = 24'hB8E38E;
    localparam logic [23:0] ECC_M4 = 24'hDF03F0;
    localparam logic [23:0] ECC_M5 = 24'hEFFC00;

    logic [7:0] ecc_calc;

    // Syndrome-free check: recompute and compare, no single-bit correction
    assign ecc_calc = {2'b00,
                       ^(in_data_i[23:0] & ECC_M5),
                       ^(in_data_i[23:0] & ECC_M4),
                       ^(in_data_i[23:0] & ECC_M3),
                       ^(in_data_i[23:0] & ECC_M2),
                       ^(in_data_i[23:0] & ECC_M1),
                       ^(in_data_i[23:0] & ECC_M0)};
    assign ecc_ok   = (ecc_calc == in_data_i[31:24]);
`else
    assign ecc_ok   = 1'b1;
`endif

    // State and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            pay_valid_o <= 1'b0;
            pay_data_o  <= '0;
            pay_last_o  <= 1'b0;
            fsync_o     <= 1'b0;
            lsync_o     <= 1'b0;
            frame_cnt_o <= '0;
            line_cnt_o  <= '0;
            err_o       <= 1'b0;
            err_code_o  <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            pay_valid_o <= pay_valid_d;
            pay_data_o  <= pay_data_d;
            pay_last_o  <= pay_last_d;
            fsync_o     <= fsync_d;
            lsync_o     <= lsync_d;
            frame_cnt_o <= frame_cnt_d;
            line_cnt_o  <= line_cnt_d;
            err_o       <= err_d;
            err_code_o  <= err_code_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        pay_valid_d = 1'b0;
        pay_data_d  = pay_data_o;
        pay_last_d  = 1'b0;
        fsync_d     = fsync_o;
        lsync_d     = lsync_o;
        frame_cnt_d = frame_cnt_o;
        line_cnt_d  = line_cnt_o;
        err_d       = 1'b0;
        err_code_d  = err_code_o;
        start_hdr   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Non-header words between packets are discarded
                if (in_valid_i && in_sop_i && enable_i) begin
                    start_hdr = 1'b1;
                end
            end

            S_PAYLOAD: begin
                if (in_valid_i) begin
                    if (in_sop_i) begin
                        // Abort the line without a last marker or line count
                        err_d      = 1'b1;
                        err_code_d = ERR_SOP;
                        lsync_d    = 1'b0;
                        state_d    = S_IDLE;
                        start_hdr  = enable_i;
                    end else begin
                        pay_valid_d = 1'b1;
                        pay_data_d  = in_data_i;
                        wcnt_d      = wcnt_q - WCNT_W'(1);
                        if (wcnt_q == WCNT_W'(1)) begin
                            pay_last_d = 1'b1;
                            lsync_d    = 1'b0;
                            line_cnt_d = line_cnt_o + CNT_W'(1);
                            state_d    = S_CRC;
                        end
                    end
                end
            end

            S_CRC: begin
                if (in_valid_i) begin
                    state_d = S_IDLE;
                    if (in_sop_i) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_SOP;
                        start_hdr  = enable_i;
                    end
                end
            end

            S_SKIP: begin
                if (in_valid_i) begin
                    if (in_sop_i) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_SOP;
                        state_d    = S_IDLE;
                        start_hdr  = enable_i;
                    end else begin
                        wcnt_d = wcnt_q - WCNT_W'(1);
                        if (wcnt_q == WCNT_W'(1)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Header decode; a header that interrupts a packet lands here too
        if (start_hdr) begin
            state_d = S_IDLE;
            if (!ecc_ok) begin
                err_d      = 1'b1;
                err_code_d = ERR_ECC;
            end else if (hdr_di == DI_FS) begin
                fsync_d    = 1'b1;
                line_cnt_d = '0;
            end else if (hdr_di == DI_FE) begin
                fsync_d     = 1'b0;
                frame_cnt_d = frame_cnt_o + CNT_W'(1);
            end else if (hdr_di == DATA_TYPE) begin
                if (hdr_wc > MAX_WC) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_WC_MAX;
                    wcnt_d     = skip_len;
                    state_d    = S_SKIP;
                end else if (hdr_wc[1:0] != 2'b00) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_WC_MOD;
                    wcnt_d     = skip_len;
                    state_d    = S_SKIP;
                end else if (hdr_wc == 16'd0) begin
                    // Empty line: only the padded CRC word follows
                    wcnt_d  = skip_len;
                    state_d = S_SKIP;
                end else begin
                    wcnt_d  = WCNT_W'(hdr_wc >> 2);
                    lsync_d = 1'b1;
                    state_d = S_PAYLOAD;
                end
            end else if (hdr_di >= 8'h10) begin
                wcnt_d  = skip_len;
                state_d = S_SKIP;
            end
        end
    end

endmodule

// File: tb/tb_csi_packet_sequencer.sv
module tb_csi_packet_sequencer;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             vld;
    logic             sop;
    logic [31:0]      din;
    logic             pay_valid;
    logic [31:0]      pay_data;
    logic             pay_last;
    logic             fsync;
    logic             lsync;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic             err;
    logic [2:0]       err_code;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csi_packet_sequencer #(
        .DATA_TYPE (8'h2B),
        .MAX_WC    (16'd4000),
        .CNT_W     (CNT_W)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .enable_i    (en),
        .in_valid_i  (vld),
        .in_sop_i    (sop),
        .in_data_i   (din),
        .pay_valid_o (pay_valid),
        .pay_data_o  (pay_data),
        .pay_last_o  (pay_last),
        .fsync_o     (fsync),
        .lsync_o     (lsync),
        .frame_cnt_o (frame_cnt),
        .line_cnt_o  (line_cnt),
        .err_o       (err),
        .err_code_o  (err_code)
    );

    // Reference Hamming(24,6) parity written out bit by bit
    function automatic logic [7:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
        return {ecc6({wc, di}), wc, di};
    endfunction

    typedef struct {
        logic        en;
        logic        vld;
        logic        sop;
        logic [31:0] data;
        logic        pv;
        logic [31:0] pd;
        logic        pl;
        logic        fs;
        logic        ls;
        logic [15:0] fc;
        logic [15:0] lc;
        logic        er;
        logic [2:0]  code;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input logic v, input logic s, input logic [31:0] d,
                                input logic pv, input logic [31:0] pd, input logic pl,
                                input logic fs, input logic ls, input logic [15:0] fc,
                                input logic [15:0] lc, input logic er, input logic [2:0] code);
        vec_t r;
        r.en = e; r.vld = v; r.sop = s; r.data = d;
        r.pv = pv; r.pd = pd; r.pl = pl; r.fs = fs; r.ls = ls;
        r.fc = fc; r.lc = lc; r.er = er; r.code = code;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one input word at the falling edge, sample just after the next rising edge
    task automatic step(input logic e, input logic v, input logic s, input logic [31:0] d);
        @(negedge clk);
        en = e; vld = v; sop = s; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pay_valid"}, 32'(pay_valid), 32'd0);
        chk({tag, ".pay_data"},  pay_data,        32'd0);
        chk({tag, ".pay_last"},  32'(pay_last),  32'd0);
        chk({tag, ".fsync"},     32'(fsync),     32'd0);
        chk({tag, ".lsync"},     32'(lsync),     32'd0);
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, ".line_cnt"},  32'(line_cnt),  32'd0);
        chk({tag, ".err"},       32'(err),       32'd0);
        chk({tag, ".err_code"},  32'(err_code),  32'd0);
    endtask

    initial begin
        int npv;
        logic [31:0] exp_q[$];

        // {en, vld, sop, data} -> {pv, pd, pl, fs, ls, fc, lc, err, code}
        tbl.push_back(mk(1,1,1,hdr(8'h00,16'd0),   0,0,0, 1,0, 0,0, 0,0)); // FS
        tbl.push_back(mk(1,1,1,hdr(8'h2B,16'd20),  0,0,0, 1,1, 0,0, 0,0)); // RAW10 WC=20
        tbl.push_back(mk(1,1,0,32'hA000_0001, 1,32'hA000_0001,0, 1,1, 0,0, 0,0));
        tbl.push_back(mk(1,1,0,32'hA000_0002, 1,32'hA000_0002,0, 1,1, 0,0, 0,0));
        tbl.push_back(mk(1,1,0,32'hA000_0003, 1,32'hA000_0003,0, 1,1, 0,0, 0,0));
        tbl.push_back(mk(1,1,0,32'hA000_0004, 1,32'hA000_0004,0, 1,1, 0,0, 0,0));
        tbl.push_back(mk(1,1,0,32'hA000_0005, 1,32'hA000_0005,1, 1,0, 0,1, 0,0)); // last
        tbl.push_back(mk(1,1,0,32'hCCCC_1234,      0,0,0, 1,0, 0,1, 0,0)); // CRC
        tbl.push_back(mk(1,1,1,hdr(8'h01,16'd0),   0,0,0, 0,0, 1,1, 0,0)); // FE
        tbl.push_back(mk(1,1,1,hdr(8'h2B,16'd22),  0,0,0, 0,0, 1,1, 1,2)); // bad WC%4
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(1,1,0,32'h5555_0000 + 32'(k), 0,0,0, 0,0, 1,1, 0,2));
        tbl.push_back(mk(1,1,0,32'hDEAD_BEEF,      0,0,0, 0,0, 1,1, 0,2)); // stray word
        tbl.push_back(mk(1,0,1,hdr(8'h00,16'd0),   0,0,0, 0,0, 1,1, 0,2)); // sop w/o valid
        tbl.push_back(mk(1,1,1,hdr(8'h12,16'd8),   0,0,0, 0,0, 1,1, 0,2)); // unsupported DI
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1,1,0,32'h6666_0000 + 32'(k), 0,0,0, 0,0, 1,1, 0,2));
        tbl.push_back(mk(1,1,1,hdr(8'h00,16'd0),   0,0,0, 1,0, 1,0, 0,2)); // FS clears lines
        tbl.push_back(mk(1,1,1,hdr(8'h2B,16'd4004),0,0,0, 1,0, 1,0, 1,1)); // WC>MAX
        tbl.push_back(mk(1,1,0,32'h7777_0000,      0,0,0, 1,0, 1,0, 0,1));
        tbl.push_back(mk(1,1,1,hdr(8'h2B,16'd8),   0,0,0, 1,1, 1,0, 1,3)); // sop in SKIP
        tbl.push_back(mk(1,1,0,32'hB100_0001, 1,32'hB100_0001,0, 1,1, 1,0, 0,3));
        tbl.push_back(mk(1,1,0,32'hB100_0002, 1,32'hB100_0002,1, 1,0, 1,1, 0,3));
        tbl.push_back(mk(1,1,0,32'hCCCC_0000,      0,0,0, 1,0, 1,1, 0,3));
        tbl.push_back(mk(0,1,1,hdr(8'h01,16'd0),   0,0,0, 1,0, 1,1, 0,3)); // disabled FE
        tbl.push_back(mk(1,1,1,hdr(8'h01,16'd0),   0,0,0, 0,0, 2,1, 0,3)); // FE
        tbl.push_back(mk(1,1,1,hdr(8'h02,16'd0),   0,0,0, 0,0, 2,1, 0,3)); // LS ignored
        tbl.push_back(mk(1,1,1,hdr(8'h2B,16'd0),   0,0,0, 0,0, 2,1, 0,3)); // WC=0
        tbl.push_back(mk(1,1,0,32'hCCCC_0001,      0,0,0, 0,0, 2,1, 0,3));
        tbl.push_back(mk(1,1,1,hdr(8'h2B,16'd4),   0,0,0, 0,1, 2,1, 0,3)); // WC=4
        tbl.push_back(mk(1,1,0,32'hC100_0001, 1,32'hC100_0001,1, 0,0, 2,2, 0,3));
        tbl.push_back(mk(1,1,0,32'hCCCC_0002,      0,0,0, 0,0, 2,2, 0,3));
        tbl.push_back(mk(1,1,1,hdr(8'h00,16'd0),   0,0,0, 1,0, 2,0, 0,3)); // FS
        tbl.push_back(mk(1,1,1,hdr(8'h2B,16'd4),   0,0,0, 1,1, 2,0, 0,3));
        tbl.push_back(mk(1,1,0,32'hC200_0001, 1,32'hC200_0001,1, 1,0, 2,1, 0,3));
        tbl.push_back(mk(1,1,0,32'hCCCC_0003,      0,0,0, 1,0, 2,1, 0,3));
        tbl.push_back(mk(1,1,1,hdr(8'h00,16'd0),   0,0,0, 1,0, 2,0, 0,3)); // FS while fsync

        // Reset state
        rst = 1'b1; en = 1'b0; vld = 1'b0; sop = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].vld, tbl[i].sop, tbl[i].data);
            chk($sformatf("v%0d.pay_valid", i), 32'(pay_valid), 32'(tbl[i].pv));
            if (tbl[i].pv)
                chk($sformatf("v%0d.pay_data", i), pay_data, tbl[i].pd);
            chk($sformatf("v%0d.pay_last", i),  32'(pay_last),  32'(tbl[i].pl));
            chk($sformatf("v%0d.fsync", i),     32'(fsync),     32'(tbl[i].fs));
            chk($sformatf("v%0d.lsync", i),     32'(lsync),     32'(tbl[i].ls));
            chk($sformatf("v%0d.frame_cnt", i), 32'(frame_cnt), 32'(tbl[i].fc));
            chk($sformatf("v%0d.line_cnt", i),  32'(line_cnt),  32'(tbl[i].lc));
            chk($sformatf("v%0d.err", i),       32'(err),       32'(tbl[i].er));
            chk($sformatf("v%0d.err_code", i),  32'(err_code),  32'(tbl[i].code));
        end

        // sop on the 3rd word of a WC=40 line: abort, FE decoded from that word
        step(1, 1, 1, hdr(8'h2B, 16'd40));
        chk("abort.lsync_on", 32'(lsync), 32'd1);
        step(1, 1, 0, 32'hD000_0001);
        step(1, 1, 0, 32'hD000_0002);
        chk("abort.pay2", pay_data, 32'hD000_0002);
        step(1, 1, 1, hdr(8'h01, 16'd0));
        chk("abort.err",       32'(err),       32'd1);
        chk("abort.err_code",  32'(err_code),  32'd3);
        chk("abort.lsync",     32'(lsync),     32'd0);
        chk("abort.pay_valid", 32'(pay_valid), 32'd0);
        chk("abort.pay_last",  32'(pay_last),  32'd0);
        chk("abort.line_cnt",  32'(line_cnt),  32'd0);
        chk("abort.fsync",     32'(fsync),     32'd0);
        chk("abort.frame_cnt", 32'(frame_cnt), 32'd3);
        step(1, 1, 0, 32'hD000_0003);
        chk("abort.idle_word", 32'(pay_valid), 32'd0);
        chk("abort.err_clr",   32'(err),       32'd0);

        // WC=16 line with valid on one cycle in three
        step(1, 1, 1, hdr(8'h2B, 16'd16));
        npv = 0;
        exp_q = {32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003};
        for (int c = 0; c < 12; c++) begin
            if (c % 3 == 2) step(1, 1, 0, 32'hE000_0000 + 32'(c / 3));
            else            step(1, 0, 0, 32'hFFFF_FFFF);
            if (pay_valid) begin
                if (npv < 4) chk($sformatf("gap.data%0d", npv), pay_data, exp_q[npv]);
                chk($sformatf("gap.last%0d", npv), 32'(pay_last), 32'(npv == 3));
                npv++;
            end
        end
        chk("gap.count",    32'(npv),      32'd4);
        chk("gap.line_cnt", 32'(line_cnt), 32'd1);
        chk("gap.lsync",    32'(lsync),    32'd0);
        step(1, 1, 0, 32'hCCCC_0004);

        // Reset in the middle of a line
        step(1, 1, 1, hdr(8'h2B, 16'd16));
        step(1, 1, 0, 32'hF000_0001);
        step(1, 1, 0, 32'hF000_0002);
        @(negedge clk);
        rst = 1'b1; vld = 1'b0; sop = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 0, 32'hF000_0003);
        chk("midrst.idle_word", 32'(pay_valid), 32'd0);
        chk("midrst.lsync",     32'(lsync),     32'd0);

        // WC == MAX_WC is accepted as a full line
        step(1, 1, 1, hdr(8'h2B, 16'd4000));
        chk("max.err",   32'(err),   32'd0);
        chk("max.lsync", 32'(lsync), 32'd1);
        npv = 0;
        for (int w = 0; w < 1000; w++) begin
            step(1, 1, 0, 32'h1000_0000 + 32'(w));
            if (pay_valid) npv++;
            if (w == 999) begin
                chk("max.last",      32'(pay_last), 32'd1);
                chk("max.last_data", pay_data,      32'h1000_03E7);
            end else if (pay_last) begin
                chk($sformatf("max.early_last%0d", w), 32'(pay_last), 32'd0);
            end
        end
        chk("max.count",    32'(npv),      32'd1000);
        chk("max.line_cnt", 32'(line_cnt), 32'd1);
        step(1, 1, 0, 32'hCCCC_0005);

`ifdef CSI_ECC_CHECK_EN
        // Corrupted ECC on FS: header dropped
        step(1, 1, 1, hdr(8'h00, 16'd0) ^ 32'h0100_0000);
        chk("ecc.err",      32'(err),      32'd1);
        chk("ecc.err_code", 32'(err_code), 32'd4);
        chk("ecc.fsync",    32'(fsync),    32'd0);
        step(1, 1, 1, hdr(8'h00, 16'd0));
        chk("ecc.good_fs",  32'(fsync),    32'd1);
        chk("ecc.good_err", 32'(err),      32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
